i2c_target: RTL and testbench

- 7-bit-addressed I2C target (slave); the responder end of the board's I2C bus, the counterpart of the existing I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and ACKs its own address.
- Hands received write bytes to user logic and fetches read bytes from it.
- Open-drain only: drives lines low or releases them to 1'bz, never drives high.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_line_monitor.sv | 45 ++++
 rtl/i2c_target.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C widths, target state encoding and open-drain line values
package i2c_pkg;
  localparam int I2cAddressWidth = 7;
  localparam int I2cByteWidth    = 8;
  localparam logic OdDriveLow = 1'b0;
  localparam logic OdRelease  = 1'bz;
  typedef enum logic [3:0] {
    Idle,
    Address,
    AddrAck,
    WriteData,
    WriteAck,
    ReadData,
    ReadAck,
    Ignore
  } state_e;
endpackage

// File: rtl/i2c_line_monitor.sv
// i2c_line_monitor: SCL/SDA synchronizers with SCL edge and START/STOP detection
module i2c_line_monitor #(
  parameter int SyncStages = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclIn,
  input  logic sdaIn,
  output logic sclRise,
  output logic sclFall,
  output logic startDet,
  output logic stopDet,
  output logic sdaSync
);
  logic [SyncStages-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic scl_s;
  // shift raw lines through the synchronizers and keep one synchronized sample of history
  always_comb begin
    scl_sync_d = {scl_sync_q[SyncStages-2:0], sclIn};
    sda_sync_d = {sda_sync_q[SyncStages-2:0], sdaIn};
    scl_hist_d = scl_sync_q[SyncStages-1];
    sda_hist_d = sda_sync_q[SyncStages-1];
  end
  // registers reset to the idle-high bus level so reset release creates no edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end
  assign scl_s    = scl_sync_q[SyncStages-1];
  assign sdaSync  = sda_sync_q[SyncStages-1];
  assign sclRise  = scl_s & ~scl_hist_q;
  assign sclFall  = ~scl_s & scl_hist_q;
  assign startDet = scl_s & scl_hist_q & sda_hist_q & ~sdaSync;
  assign stopDet  = scl_s & scl_hist_q & ~sda_hist_q & sdaSync;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C target; define I2C_TARGET_CLOCK_STRETCH_EN to stretch SCL until txValid on reads
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2cAddressWidth-1:0] TargetAddress = 7'h50,
  parameter int SyncStages = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  inout  wire                     sda,
  inout  wire                     scl,
  output logic [I2cByteWidth-1:0] rxData,
  output logic                    rxValid,
  input  logic [I2cByteWidth-1:0] txData,
  output logic                    txRequest,
  input  logic                    txValid,
  output logic                    busy,
  output logic                    readMode,
  output logic                    stopSeen
);
  state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [I2cByteWidth-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic busy_q, busy_d, read_mode_q, read_mode_d, stop_seen_q, stop_seen_d;
  logic load_tx;
  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  logic scl_oe_q, scl_oe_d, stretch_q, stretch_d;
`else
  logic unused_tx_valid;
  assign unused_tx_valid = txValid;
`endif

  i2c_line_monitor #(.SyncStages(SyncStages)) u_mon (
    .clock    (clock),
    .reset    (reset),
    .sclIn    (scl),
    .sdaIn    (sda),
    .sclRise  (scl_rise),
    .sclFall  (scl_fall),
    .startDet (start_det),
    .stopDet  (stop_det),
    .sdaSync  (sda_sync)
  );

  // bus protocol sequencing; START/STOP override any bit-level activity in the same clock
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    read_mode_d = read_mode_q;
    stop_seen_d = 1'b0;
    load_tx     = 1'b0;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    tx_req_d    = tx_req_q & ~txValid;
    scl_oe_d    = scl_oe_q & stretch_q;
    stretch_d   = stretch_q;
`else
    tx_req_d    = 1'b0;
`endif
    if (stop_det) begin
      state_d     = Idle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = 4'd0;
      stop_seen_d = 1'b1;
    end else if (start_det) begin
      state_d   = Address;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        Address: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[I2cByteWidth-2:0], sda_sync};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (shift_q[I2cAddressWidth-1:0] == TargetAddress) begin
                read_mode_d = sda_sync;
                busy_d      = 1'b1;
              end else begin
                state_d = Ignore;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = AddrAck;
          end
        end
        AddrAck: begin
          if (scl_rise && read_mode_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            load_tx   = read_mode_q;
            state_d   = read_mode_q ? ReadData : WriteData;
          end
        end
        WriteData: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[I2cByteWidth-2:0], sda_sync};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            sda_oe_d   = 1'b1;
            state_d    = WriteAck;
          end
        end
        WriteAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = WriteData;
          end
        end
        ReadData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ReadAck;
            end else begin
              shift_d   = {shift_q[I2cByteWidth-2:0], 1'b0};
              sda_oe_d  = ~shift_q[I2cByteWidth-2];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ReadAck: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd8;
            end else begin
              busy_d  = 1'b0;
              state_d = Ignore;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            load_tx   = 1'b1;
            state_d   = ReadData;
          end
        end
        default: ;
      endcase
    end
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    if (load_tx) begin
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b1;
      stretch_d = 1'b1;
    end
    if (stretch_q && txValid) begin
      shift_d   = txData;
      sda_oe_d  = ~txData[I2cByteWidth-1];
      stretch_d = 1'b0;
      tx_req_d  = 1'b0;
    end
`else
    if (load_tx) begin
      shift_d  = txData;
      sda_oe_d = ~txData[I2cByteWidth-1];
    end
`endif
  end

  // protocol state and registered outputs; reset releases the bus immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= Idle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      read_mode_q <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      read_mode_q <= read_mode_d;
      stop_seen_q <= stop_seen_d;
    end
  end

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  // SCL hold-low while waiting for user read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scl_oe_q  <= 1'b0;
      stretch_q <= 1'b0;
    end else begin
      scl_oe_q  <= scl_oe_d;
      stretch_q <= stretch_d;
    end
  end
  assign scl = scl_oe_q ? OdDriveLow : OdRelease;
`else
  assign scl = OdRelease;
`endif

  assign sda       = sda_oe_q ? OdDriveLow : OdRelease;
  assign rxData    = rx_data_q;
  assign rxValid   = rx_valid_q;
  assign txRequest = tx_req_q;
  assign busy      = busy_q;
  assign readMode  = read_mode_q;
  assign stopSeen  = stop_seen_q;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed open-drain I2C master bench for i2c_target
module tb_i2c_target;
  logic clk = 1'b0;
  logic rst_n;
  logic m_sda, m_scl;
  logic [7:0] tx_data, rx_data;
  logic tx_valid, rx_valid, tx_request, busy, read_mode, stop_seen;
  wire sda, scl;
  int n_assert = 0;
  int n_fail = 0;
  int rx_cnt = 0, tx_req_cnt = 0, stop_cnt = 0, overlap_cnt = 0;
  logic tx_req_prev = 1'b0;
  logic [7:0] rx_log [16];

  always #5 clk = ~clk;

  pullup pu_sda (sda);
  pullup pu_scl (scl);
  assign sda = m_sda ? 1'bz : 1'b0;
  assign scl = m_scl ? 1'bz : 1'b0;

  i2c_target dut (
    .clock     (clk),
    .reset     (rst_n),
    .sda       (sda),
    .scl       (scl),
    .rxData    (rx_data),
    .rxValid   (rx_valid),
    .txData    (tx_data),
    .txRequest (tx_request),
    .txValid   (tx_valid),
    .busy      (busy),
    .readMode  (read_mode),
    .stopSeen  (stop_seen)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 16] = rx_data;
      rx_cnt++;
    end
    if (tx_request && !tx_req_prev) tx_req_cnt++;
    tx_req_prev = tx_request;
    if (stop_seen) stop_cnt++;
    if (rx_valid && tx_request) overlap_cnt++;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait();
    repeat (10) @(negedge clk);
  endtask

  task automatic scl_up();
    int k = 0;
    m_scl = 1'b1;
    while (scl !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("scl_high", scl, 1'b1);
  endtask

  task automatic bit_tx(input logic b, output logic r);
    m_sda = b;
    q_wait();
    scl_up();
    q_wait();
    r = sda;
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    q_wait();
    scl_up();
    q_wait();
    m_sda = 1'b0;
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    q_wait();
    scl_up();
    q_wait();
    m_sda = 1'b1;
    q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_tx(d[i], r);
    bit_tx(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_tx(1'b1, r);
      d[i] = r;
    end
    tx_data = next_tx;
    bit_tx(nack, r);
  endtask

  initial begin
    logic ack;
    logic [7:0] rd;
    int base_rx, base_stop, base_tx;
    rst_n = 1'b0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sda", sda, 1'b1);
    chk("rst_scl", scl, 1'b1);
    chk("rst_rxdata", rx_data, 8'h00);
    chk("rst_rxvalid", rx_valid, 1'b0);
    chk("rst_txreq", tx_request, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_readmode", read_mode, 1'b0);
    chk("rst_stopseen", stop_seen, 1'b0);
    rst_n = 1'b1;
    q_wait();

    base_rx = rx_cnt;
    base_stop = stop_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("t1_addr_ack", ack, 1'b0);
    chk("t1_busy_set", busy, 1'b1);
    chk("t1_readmode", read_mode, 1'b0);
    write_byte(8'h12, ack);
    chk("t1_d0_ack", ack, 1'b0);
    write_byte(8'h34, ack);
    chk("t1_d1_ack", ack, 1'b0);
    i2c_stop();
    q_wait();
    chk("t1_rx_count", 8'(rx_cnt - base_rx), 8'd2);
    chk("t1_rx_first", rx_log[base_rx % 16], 8'h12);
    chk("t1_rx_second", rx_log[(base_rx + 1) % 16], 8'h34);
    chk("t1_stop_count", 8'(stop_cnt - base_stop), 8'd1);
    chk("t1_busy_clear", busy, 1'b0);

    base_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    chk("t2_addr_nack", ack, 1'b1);
    chk("t2_busy", busy, 1'b0);
    write_byte(8'h55, ack);
    chk("t2_data_nack", ack, 1'b1);
    chk("t2_busy_after", busy, 1'b0);
    i2c_stop();
    q_wait();
    chk("t2_no_rx", 8'(rx_cnt - base_rx), 8'd0);

    base_tx = tx_req_cnt;
    tx_data = 8'hC5;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("t3_addr_ack", ack, 1'b0);
    chk("t3_readmode", read_mode, 1'b1);
    chk("t3_busy", busy, 1'b1);
    read_byte(1'b0, 8'h3A, rd);
    chk("t3_byte0", rd, 8'hC5);
    read_byte(1'b1, 8'hFF, rd);
    chk("t3_byte1", rd, 8'h3A);
    chk("t3_sda_released", sda, 1'b1);
    chk("t3_busy_nack", busy, 1'b0);
    i2c_stop();
    q_wait();
    chk("t3_txreq_count", 8'(tx_req_cnt - base_tx), 8'd2);

    tx_data = 8'h9B;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("t4_addr_ack", ack, 1'b0);
    chk("t4_readmode_w", read_mode, 1'b0);
    write_byte(8'h07, ack);
    chk("t4_data_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack);
    chk("t4_raddr_ack", ack, 1'b0);
    chk("t4_readmode_r", read_mode, 1'b1);
    read_byte(1'b1, 8'h00, rd);
    chk("t4_read", rd, 8'h9B);
    i2c_stop();
    q_wait();
    chk("t4_rxdata", rx_data, 8'h07);

    tx_data = 8'hE5;
    i2c_start();
    write_byte(8'hA1, ack);
    chk("t5_addr_ack", ack, 1'b0);
    for (int i = 0; i < 3; i++) bit_tx(1'b1, ack);
    m_sda = 1'b1;
    q_wait();
    scl_up();
    q_wait();
    chk("t5_bit4_low", sda, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_sda_release", sda, 1'b1);
    chk("t5_rxdata", rx_data, 8'h00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_readmode", read_mode, 1'b0);
    chk("t5_txreq", tx_request, 1'b0);
    chk("t5_rxvalid", rx_valid, 1'b0);
    chk("t5_stopseen", stop_seen, 1'b0);
    rst_n = 1'b1;
    q_wait();
    m_scl = 1'b0;
    q_wait();
    base_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    chk("t5_w_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    chk("t5_w_data_ack", ack, 1'b0);
    i2c_stop();
    q_wait();
    chk("t5_w_rxdata", rx_data, 8'h5A);
    chk("t5_w_rx_count", 8'(rx_cnt - base_rx), 8'd1);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    begin
      int highs = 0;
      tx_valid = 1'b0;
      tx_data = 8'h6D;
      i2c_start();
      write_byte(8'hA1, ack);
      chk("t6_addr_ack", ack, 1'b0);
      m_scl = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_txreq_level", tx_request, 1'b1);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (scl === 1'b1) highs++;
      end
      chk("t6_scl_held", 8'(highs), 8'd0);
      tx_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_scl_released", scl, 1'b1);
      chk("t6_txreq_drop", tx_request, 1'b0);
      q_wait();
      rd[7] = sda;
      q_wait();
      m_scl = 1'b0;
      q_wait();
      for (int i = 6; i >= 0; i--) begin
        bit_tx(1'b1, ack);
        rd[i] = ack;
      end
      bit_tx(1'b1, ack);
      chk("t6_byte", rd, 8'h6D);
      i2c_stop();
      q_wait();
    end
`endif

    chk("no_rx_tx_overlap", 8'(overlap_cnt), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
